// File: rtl/pq_access_scheduler.sv
// rtl/pq_access_scheduler.sv - round-robin arbiter serialising requester ops onto a register-tree priority queue
module pq_access_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                          i_CLK,
   input  logic                          i_RST,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ-1:0]            i_req_op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
   output logic [DATA_WIDTH-1:0]         o_rsp_data,
   output logic                          o_rsp_err,
   output logic                          o_pq_wrt,
   output logic                          o_pq_read,
   output logic [DATA_WIDTH-1:0]         o_pq_data,
   input  logic                          i_pq_full,
   input  logic                          i_pq_empty,
   input  logic [DATA_WIDTH-1:0]         i_pq_data,
   output logic                          o_busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [IDW-1:0]        ptr;
   logic                  op_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDW-1:0]        id_q;

   logic [NUM_REQ-1:0]    grant;
   logic [IDW-1:0]        gid;
   logic                  gop;
   logic [DATA_WIDTH-1:0] gdata;
   logic                  found;
   logic                  accept;
   logic                  op_err;

   // Two passes: requesters at or above the pointer first, then the wrap-around.
   always_comb begin
      grant = '0;
      gid   = '0;
      gop   = 1'b0;
      gdata = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && j >= int'(ptr) && i_req_valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            gid      = IDW'(j);
            gop      = i_req_op[j];
            gdata    = i_req_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && j < int'(ptr) && i_req_valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            gid      = IDW'(j);
            gop      = i_req_op[j];
            gdata    = i_req_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign accept      = (state == IDLE) && found;
   assign o_req_ready = (state == IDLE) ? grant : '0;
   assign op_err      = op_q ? i_pq_empty : i_pq_full;
   assign o_pq_wrt    = (state == ISSUE) && !op_q && !i_pq_full;
   assign o_pq_read   = (state == ISSUE) && op_q && !i_pq_empty;
   assign o_pq_data   = o_pq_wrt ? data_q : '0;
   assign o_busy      = (state != IDLE);

   always_ff @(posedge i_CLK) begin
      if (i_RST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = ISSUE;
         ISSUE:   state_nxt = op_err ? IDLE : SETTLE;
         SETTLE:  if (cnt <= CW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         cnt         <= '0;
         ptr         <= '0;
         op_q        <= 1'b0;
         data_q      <= '0;
         id_q        <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_rsp_data  <= '0;
         o_rsp_err   <= 1'b0;
      end else begin
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_rsp_data  <= '0;
         o_rsp_err   <= 1'b0;
         if (accept) begin
            op_q   <= gop;
            data_q <= gdata;
            id_q   <= gid;
            ptr    <= (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + IDW'(1);
         end
         if (state == ISSUE) begin
            o_rsp_valid <= 1'b1;
            o_rsp_id    <= id_q;
            o_rsp_err   <= op_err;
            o_rsp_data  <= (op_q && !i_pq_empty) ? i_pq_data : '0;
            if (!op_err) cnt <= CW'(SETTLE_CYCLES);
         end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pq_access_scheduler.sv
// tb/tb_pq_access_scheduler.sv - directed self-checking bench for pq_access_scheduler
module tb_pq_access_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  valid, op;
   logic [63:0] rdata;
   logic [3:0]  ready;
   logic        rsp_valid, rsp_err, pq_wrt, pq_read, busy;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data, pq_data, pq_head;
   logic        pq_full, pq_empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pq_access_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16), .SETTLE_CYCLES(4)) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_req_valid(valid), .i_req_op(op), .i_req_data(rdata),
      .o_req_ready(ready),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
      .o_pq_wrt(pq_wrt), .o_pq_read(pq_read), .o_pq_data(pq_data),
      .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_head),
      .o_busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_g [5];
      int last, n, waited;
      bit saw_rsp;
      exp_g = '{0, 1, 2, 3, 0};

      rst = 1'b1; valid = '0; op = '0; rdata = '0;
      pq_full = 1'b0; pq_empty = 1'b0; pq_head = '0;
      tick; tick;
      rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_wrt", pq_wrt, 0);
      check("rst_read", pq_read, 0);
      check("rst_pq_data", pq_data, 0);
      check("idle_no_ready", ready, 0);

      // enqueue 0x0025 from req0
      valid = 4'b0001; op = 4'b0000; rdata[15:0] = 16'h0025;
      #1 check("enq_ready", ready, 4'b0001);
      tick; valid = '0;
      #1;
      check("enq_wrt", pq_wrt, 1);
      check("enq_pq_data", pq_data, 16'h0025);
      check("enq_read", pq_read, 0);
      check("enq_busy", busy, 1);
      check("issue_ready", ready, 0);
      tick; #1;
      check("enq_rsp_valid", rsp_valid, 1);
      check("enq_rsp_id", rsp_id, 0);
      check("enq_rsp_err", rsp_err, 0);
      check("enq_rsp_data", rsp_data, 0);
      check("settle_wrt", pq_wrt, 0);
      tick; tick; tick; #1;
      check("settle_busy_t5", busy, 1);
      tick; #1;
      check("idle_busy_t6", busy, 0);
      check("rsp_one_cycle", rsp_valid, 0);

      // dequeue by req2 with head 0x0040
      pq_head = 16'h0040; valid = 4'b0100; op = 4'b0100;
      #1 check("deq_ready", ready, 4'b0100);
      tick; valid = '0;
      #1;
      check("deq_read", pq_read, 1);
      check("deq_wrt", pq_wrt, 0);
      check("deq_pq_data", pq_data, 0);
      tick; #1;
      check("deq_rsp_valid", rsp_valid, 1);
      check("deq_rsp_id", rsp_id, 2);
      check("deq_rsp_data", rsp_data, 16'h0040);
      check("deq_rsp_err", rsp_err, 0);
      repeat (4) tick;
      #1 check("deq_idle", busy, 0);

      // continuous enqueues from all requesters after a fresh reset
      rst = 1'b1; tick; rst = 1'b0;
      valid = 4'hF; op = '0; rdata = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
      last = -1; n = 0;
      for (int c = 0; c < 60 && n < 5; c++) begin
         #1;
         if (pq_wrt) check("rr_wdata", pq_data, 16'h000A + exp_g[n-1]);
         if (ready != 0) begin
            check("rr_grant", ready, 1 << exp_g[n]);
            if (n > 0) check("rr_spacing", c - last, 6);
            last = c;
            n++;
         end
         tick;
      end
      check("rr_count", n, 5);
      valid = '0;
      waited = 0;
      while (busy && waited < 20) begin tick; waited++; end
      check("rr_drain", busy, 0);

      // dequeue on empty from req1, held valid to show the 2-cycle turnaround
      pq_empty = 1'b1; valid = 4'b0010; op = 4'b0010;
      #1 check("empty_ready", ready, 4'b0010);
      tick; #1;
      check("empty_no_read", pq_read, 0);
      check("empty_no_wrt", pq_wrt, 0);
      tick; #1;
      check("empty_rsp_valid", rsp_valid, 1);
      check("empty_rsp_id", rsp_id, 1);
      check("empty_rsp_err", rsp_err, 1);
      check("empty_rsp_data", rsp_data, 0);
      check("empty_idle", busy, 0);
      check("empty_reaccept", ready, 4'b0010);
      tick; valid = '0;
      #1 check("empty2_no_read", pq_read, 0);
      tick; #1;
      check("empty2_rsp_err", rsp_err, 1);

      // enqueue on full from req3
      pq_empty = 1'b0; pq_full = 1'b1;
      valid = 4'b1000; op = '0; rdata[63:48] = 16'h0001;
      #1 check("full_ready", ready, 4'b1000);
      tick; valid = '0;
      #1 check("full_no_wrt", pq_wrt, 0);
      tick; #1;
      check("full_rsp_valid", rsp_valid, 1);
      check("full_rsp_id", rsp_id, 3);
      check("full_rsp_err", rsp_err, 1);
      check("full_rsp_data", rsp_data, 0);

      // reset in the middle of settle
      pq_full = 1'b0; valid = 4'b0010; op = '0; rdata[31:16] = 16'h0077;
      #1 check("abort_ready", ready, 4'b0010);
      tick; valid = '0;
      #1 check("abort_wrt", pq_wrt, 1);
      tick; #1 check("abort_rsp", rsp_valid, 1);
      tick; rst = 1'b1;
      #1 check("abort_busy_pre", busy, 1);
      tick; rst = 1'b0; valid = 4'hF;
      #1;
      check("abort_busy", busy, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_wrt_low", pq_wrt, 0);
      check("abort_read_low", pq_read, 0);
      check("abort_pq_data", pq_data, 0);
      check("abort_ptr", ready, 4'b0001);
      valid = '0;
      saw_rsp = 1'b0;
      repeat (4) begin
         tick; #1;
         if (rsp_valid || pq_wrt || pq_read || busy) saw_rsp = 1'b1;
      end
      check("abort_quiet", saw_rsp, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pq_access_scheduler.md
PQ_ACCESS_SCHEDULER -- requirements
Module: pq_access_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (at least 2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the key width, matching the register-tree queue.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 4, the idle cycles the tree needs after each write/read to restore heap order (at least 1).
REQ-004 The block SHALL have the port i_CLK, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have the port i_RST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port i_req_valid, input, NUM_REQ bits: per-requester request valid.
REQ-007 The block SHALL have the port i_req_op, input, NUM_REQ bits: per-requester operation, 0 = enqueue, 1 = dequeue.
REQ-008 The block SHALL have the port i_req_data, input, NUM_REQ*DATA_WIDTH bits: enqueue key, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have the port o_req_ready, output, NUM_REQ bits: one-hot grant, at most one bit high.
REQ-010 The block SHALL have the port o_rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have the port o_rsp_id, output, $clog2(NUM_REQ) bits: index of the completed requester.
REQ-012 The block SHALL have the port o_rsp_data, output, DATA_WIDTH bits: dequeued key; 0 for enqueues and errors.
REQ-013 The block SHALL have the port o_rsp_err, output, 1 bit: the operation was rejected (enqueue on full, dequeue on empty).
REQ-014 The block SHALL have the ports o_pq_wrt and o_pq_read, outputs, 1 bit each: queue write strobe and queue read strobe.
REQ-015 The block SHALL have the port o_pq_data, output, DATA_WIDTH bits: key presented to the queue.
REQ-016 The block SHALL have the ports i_pq_full and i_pq_empty, inputs, 1 bit each: queue status.
REQ-017 The block SHALL have the port i_pq_data, input, DATA_WIDTH bits: queue head.
REQ-018 The block SHALL have the port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and SETTLE.
REQ-020 In IDLE, o_req_ready SHALL be a combinational round-robin grant over i_req_valid, starting at the requester after the last granted one (requester 0 first after reset).
REQ-021 A request is accepted in a cycle T in which it is valid and ready; the block SHALL latch its op, data and id, and move the round-robin pointer to the granted index plus 1, modulo NUM_REQ.
REQ-022 On acceptance, the FSM SHALL go from IDLE to ISSUE; with no valid requests it SHALL stay in IDLE with o_req_ready = 0.
REQ-023 In ISSUE (cycle T+1), the block SHALL sample i_pq_full, i_pq_empty and i_pq_data.
REQ-024 In ISSUE, an enqueue with i_pq_full = 0 SHALL assert o_pq_wrt with o_pq_data = the latched key.
REQ-025 In ISSUE, a dequeue with i_pq_empty = 0 SHALL assert o_pq_read and capture i_pq_data as the response data.
REQ-026 In ISSUE, an enqueue on full or a dequeue on empty SHALL assert no strobe and flag an error.
REQ-027 o_pq_wrt and o_pq_read SHALL never be high together; each strobe SHALL be high for exactly one cycle per issued operation.
REQ-028 o_pq_data SHALL be 0 whenever o_pq_wrt is low.
REQ-029 At T+2, o_rsp_valid SHALL pulse high for one cycle with o_rsp_id, o_rsp_data and o_rsp_err; there is no response backpressure.
REQ-030 After an issued operation, the FSM SHALL go from ISSUE to SETTLE, hold both strobes low for exactly SETTLE_CYCLES cycles, then return to IDLE.
REQ-031 An error operation SHALL go from ISSUE directly to IDLE.
REQ-032 Minimum spacing between accepts SHALL therefore be 2+SETTLE_CYCLES cycles for an issued operation and 2 cycles for an error.
REQ-033 The settle counter SHALL be $clog2(SETTLE_CYCLES+1) bits wide, load SETTLE_CYCLES on entry to SETTLE, and decrement to 0 without wrapping.
REQ-034 A requester that drops i_req_valid before being granted SHALL be ignored without error; valid/op/data are sampled only at acceptance.
REQ-035 No request SHALL be accepted outside IDLE; o_req_ready SHALL be 0 in ISSUE and SETTLE.

Reset
REQ-036 While i_RST is high at a clock edge, the block SHALL force state to IDLE, the settle counter to 0 and the round-robin pointer to 0.
REQ-037 Reset SHALL force o_pq_wrt, o_pq_read, o_pq_data, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err and o_busy to 0.
REQ-038 Reset asserted mid-ISSUE or mid-SETTLE SHALL abort the operation with no response and no further strobes; the in-flight op is dropped.

Verification
REQ-039 Scenario: after reset, req0 enqueues 0x0025 at T -> o_pq_wrt = 1 with o_pq_data = 0x0025 at T+1; o_rsp_valid, id 0, err 0, data 0 at T+2; o_busy low from T+6 (SETTLE_CYCLES = 4).
REQ-040 Scenario: queue head 0x0040, req2 dequeues -> o_pq_read pulse at T+1; response at T+2 with id 2, data 0x0040, err 0.
REQ-041 Scenario: all 4 requesters hold valid enqueues continuously -> grants go 0,1,2,3,0, with accepts spaced exactly 6 cycles apart.
REQ-042 Scenario: i_pq_empty = 1, req1 dequeues -> no strobe; response id 1, err 1, data 0; next accept possible at T+2.
REQ-043 Scenario: i_pq_full = 1, req3 enqueues 0x0001 -> no o_pq_wrt; response err 1.
REQ-044 Scenario: i_RST asserted at cycle T+3 of an issued op -> next cycle all outputs 0 and state IDLE, no o_rsp_valid; the next accept grants req0.
